// File: rtl/iob_cache_axi_pkg.sv
// Shared FSM encoding and AXI constants for the cache AXI read/write channels.
package iob_cache_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } axi_state_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

  // A line of exactly one BE word still needs a 1-bit index port.
  function automatic int cnt_w(input int line2be_w);
    return (line2be_w > 0) ? line2be_w : 1;
  endfunction

endpackage

// File: rtl/iob_cache_read_channel_axi.sv
// AXI4 read initiator for cache line fills: one AR per line, R beats written into the line.
// Optional build macro IOB_CACHE_READ_RLAST_CHECK_EN adds the sticky rlast_err_o flag.
//   state | meaning
//   IDLE  | waiting for replace_valid_i
//   ADDR  | AR issued for line_addr_q, waiting for arready
//   DATA  | accepting R beats; error or clean end decides retry or done
module iob_cache_read_channel_axi
  import iob_cache_axi_pkg::*;
#(
  parameter int          ADDR_W               = 24,
  parameter int          FE_DATA_W            = 32,
  parameter int          BE_ADDR_W            = 24,
  parameter int          BE_DATA_W            = 32,
  parameter int          WORD_OFFSET_W        = 3,
  parameter int          AXI_ID_W             = 1,
  parameter int          AXI_ID               = 0,
  parameter int          AXI_LEN_W            = 8,
  parameter logic [3:0]  CACHE_AXI_CACHE_MODE = 4'b0011,
  localparam int         FE_NBYTES_W          = $clog2(FE_DATA_W / 8),
  localparam int         BE_NBYTES_W          = $clog2(BE_DATA_W / 8),
  localparam int         LINE2BE_W            = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
  localparam int         CNT_W                = cnt_w(LINE2BE_W),
  localparam int         LADDR_W              = ADDR_W - FE_NBYTES_W - WORD_OFFSET_W
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 replace_valid_i,
  input  logic [LADDR_W-1:0]   replace_addr_i,
  output logic                 replace_o,
  output logic                 read_valid_o,
  output logic [CNT_W-1:0]     read_addr_o,
  output logic [BE_DATA_W-1:0] read_data_o,
  output logic [AXI_ID_W-1:0]  axi_arid_o,
  output logic [BE_ADDR_W-1:0] axi_araddr_o,
  output logic [AXI_LEN_W-1:0] axi_arlen_o,
  output logic [2:0]           axi_arsize_o,
  output logic [1:0]           axi_arburst_o,
  output logic                 axi_arlock_o,
  output logic [3:0]           axi_arcache_o,
  output logic [2:0]           axi_arprot_o,
  output logic [3:0]           axi_arqos_o,
  output logic                 axi_arvalid_o,
  input  logic                 axi_arready_i,
  input  logic [AXI_ID_W-1:0]  axi_rid_i,
  input  logic [BE_DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]           axi_rresp_i,
  input  logic                 axi_rlast_i,
  input  logic                 axi_rvalid_i,
`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
  output logic                 rlast_err_o,
`endif
  output logic                 axi_rready_o
);

  axi_state_t         state_q, state_d;
  logic [LADDR_W-1:0] line_addr_q, line_addr_d;
  logic               err_q, err_d;
  logic               ar_hs;
  logic               beat;
  logic               last_beat;
  logic               resp_ok;

  assign ar_hs   = (state_q == ADDR) && axi_arready_i;
  assign resp_ok = (axi_rresp_i == AXI_RESP_OKAY);

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    err_d       = err_q;
    beat        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (replace_valid_i) begin
          line_addr_d = replace_addr_i;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (axi_arready_i) begin
          err_d   = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (axi_rvalid_i) begin
          beat = 1'b1;
          if (!resp_ok) err_d = 1'b1;
          // A bad beat anywhere in the burst refetches the whole line.
          if (last_beat) state_d = (err_q || !resp_ok) ? ADDR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      err_q       <= err_d;
    end
  end

  generate
    if (LINE2BE_W > 0) begin : g_burst
      logic [LINE2BE_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (ar_hs)     cnt_d = '0;
        else if (beat) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end

      assign last_beat     = &cnt_q;
      assign read_addr_o   = cnt_q;
      assign axi_arlen_o   = AXI_LEN_W'((1 << LINE2BE_W) - 1);
      assign axi_arburst_o = AXI_BURST_INCR;
    end else begin : g_single
      assign last_beat     = 1'b1;
      assign read_addr_o   = '0;
      assign axi_arlen_o   = '0;
      assign axi_arburst_o = AXI_BURST_FIXED;
    end
  endgenerate

`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
  logic rlast_err_q, rlast_err_d;

  assign rlast_err_d = rlast_err_q | (beat & (axi_rlast_i != last_beat));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rlast_err_q <= 1'b0;
    else          rlast_err_q <= rlast_err_d;
  end

  assign rlast_err_o = rlast_err_q;
`endif

  // rid is never checked, and rlast only feeds the optional checker.
  logic unused_inputs;
  assign unused_inputs = ^{axi_rid_i, axi_rlast_i};

  assign replace_o     = (state_q != IDLE);
  assign axi_arvalid_o = (state_q == ADDR);
  assign axi_rready_o  = (state_q == DATA);
  assign read_valid_o  = beat & resp_ok & ~err_q;
  assign read_data_o   = axi_rdata_i;

  assign axi_arid_o    = AXI_ID_W'(AXI_ID);
  assign axi_araddr_o  = BE_ADDR_W'({line_addr_q, {(FE_NBYTES_W + WORD_OFFSET_W){1'b0}}});
  assign axi_arsize_o  = 3'(BE_NBYTES_W);
  assign axi_arlock_o  = 1'b0;
  assign axi_arcache_o = CACHE_AXI_CACHE_MODE;
  assign axi_arprot_o  = 3'b000;
  assign axi_arqos_o   = 4'b0000;

endmodule

// File: tb/tb_iob_cache_read_channel_axi.sv
// Directed bench for iob_cache_read_channel_axi: 8-beat line instance and single-beat instance.
module tb_iob_cache_read_channel_axi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 8-beat line instance
  logic        replace_valid, replace, read_valid, arlock, arvalid, arready, rlast, rvalid, rready;
  logic [18:0] replace_addr;
  logic [2:0]  read_addr, arsize, arprot;
  logic [31:0] read_data, rdata;
  logic [0:0]  arid, rid;
  logic [23:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst, rresp;
  logic [3:0]  arcache, arqos;
  // single-beat instance
  logic        s_replace_valid, s_replace, s_read_valid, s_arlock, s_arvalid, s_arready;
  logic        s_rlast, s_rvalid, s_rready;
  logic [21:0] s_replace_addr;
  logic [0:0]  s_read_addr, s_arid, s_rid;
  logic [2:0]  s_arsize, s_arprot;
  logic [31:0] s_read_data, s_rdata;
  logic [23:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [1:0]  s_arburst, s_rresp;
  logic [3:0]  s_arcache, s_arqos;
`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
  logic rlast_err, s_rlast_err;
`endif

  iob_cache_read_channel_axi dut (
    .clk_i(clk), .reset_i(rst_n),
    .replace_valid_i(replace_valid), .replace_addr_i(replace_addr), .replace_o(replace),
    .read_valid_o(read_valid), .read_addr_o(read_addr), .read_data_o(read_data),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache),
    .axi_arprot_o(arprot), .axi_arqos_o(arqos), .axi_arvalid_o(arvalid),
    .axi_arready_i(arready), .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp),
    .axi_rlast_i(rlast), .axi_rvalid_i(rvalid),
`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
    .rlast_err_o(rlast_err),
`endif
    .axi_rready_o(rready)
  );

  iob_cache_read_channel_axi #(.WORD_OFFSET_W(0)) dut_s (
    .clk_i(clk), .reset_i(rst_n),
    .replace_valid_i(s_replace_valid), .replace_addr_i(s_replace_addr), .replace_o(s_replace),
    .read_valid_o(s_read_valid), .read_addr_o(s_read_addr), .read_data_o(s_read_data),
    .axi_arid_o(s_arid), .axi_araddr_o(s_araddr), .axi_arlen_o(s_arlen), .axi_arsize_o(s_arsize),
    .axi_arburst_o(s_arburst), .axi_arlock_o(s_arlock), .axi_arcache_o(s_arcache),
    .axi_arprot_o(s_arprot), .axi_arqos_o(s_arqos), .axi_arvalid_o(s_arvalid),
    .axi_arready_i(s_arready), .axi_rid_i(s_rid), .axi_rdata_i(s_rdata), .axi_rresp_i(s_rresp),
    .axi_rlast_i(s_rlast), .axi_rvalid_i(s_rvalid),
`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
    .rlast_err_o(s_rlast_err),
`endif
    .axi_rready_o(s_rready)
  );

  // Accept a request on the next edge; returns 1 time unit after acceptance (state ADDR).
  task automatic req_main(input logic [18:0] a, input logic rdy);
    @(posedge clk); #1;
    replace_valid = 1'b1; replace_addr = a; arready = rdy;
    @(posedge clk); #1;
    replace_valid = 1'b0; replace_addr = 19'h7FFFF;
  endtask

  task automatic test_reset();
    rvalid = 1'b1; s_rvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if ({replace, arvalid, rready, read_valid} !== 4'b0000) begin
      n_err++; $display("FAIL rst_outputs: got %b exp 0000", {replace, arvalid, rready, read_valid}); end
    n_cmp++; if ({s_replace, s_arvalid, s_rready, s_read_valid} !== 4'b0000) begin
      n_err++; $display("FAIL rst_s_outputs: got %b exp 0000", {s_replace, s_arvalid, s_rready, s_read_valid}); end
    n_cmp++; if (araddr !== 24'h0) begin
      n_err++; $display("FAIL rst_araddr: got %h exp 000000", araddr); end
`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
    n_cmp++; if ({rlast_err, s_rlast_err} !== 2'b00) begin
      n_err++; $display("FAIL rst_rlast_err: got %b exp 00", {rlast_err, s_rlast_err}); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; rvalid = 1'b0; s_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({replace, arvalid, rready} !== 3'b000) begin
      n_err++; $display("FAIL rst_release_idle: got %b exp 000", {replace, arvalid, rready}); end
  endtask

  task automatic test_burst_ok();
    @(posedge clk); #1;
    replace_valid = 1'b1; replace_addr = 19'h01234; arready = 1'b1;
    @(negedge clk);
    n_cmp++; if (replace !== 1'b0) begin
      n_err++; $display("FAIL bok_replace_before: got %b exp 0", replace); end
    @(posedge clk); #1;
    replace_valid = 1'b0; replace_addr = 19'h7FFFF;
    @(negedge clk);
    n_cmp++; if ({arvalid, replace, rready} !== 3'b110) begin
      n_err++; $display("FAIL bok_addr_state: got %b exp 110", {arvalid, replace, rready}); end
    n_cmp++; if (araddr !== 24'h024680) begin
      n_err++; $display("FAIL bok_araddr: got %h exp 024680", araddr); end
    n_cmp++; if ({arlen, arburst, arsize, arcache, arlock, arprot, arqos, arid} !==
                 {8'd7, 2'b01, 3'd2, 4'b0011, 1'b0, 3'b000, 4'b0000, 1'b0}) begin
      n_err++; $display("FAIL bok_ar_fields: got len=%0d burst=%b size=%0d cache=%b exp len=7 burst=01 size=2 cache=0011",
                        arlen, arburst, arsize, arcache); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rvalid = 1'b1; rresp = 2'b00; rdata = 32'hBEEF0000 + 32'(k); rlast = (k == 7);
      @(negedge clk);
      n_cmp++; if ({read_valid, rready, replace, arvalid} !== 4'b1110) begin
        n_err++; $display("FAIL bok_beat_ctrl[%0d]: got %b exp 1110", k, {read_valid, rready, replace, arvalid}); end
      n_cmp++; if (read_addr !== 3'(k)) begin
        n_err++; $display("FAIL bok_read_addr[%0d]: got %0d exp %0d", k, read_addr, k); end
      n_cmp++; if (read_data !== 32'hBEEF0000 + 32'(k)) begin
        n_err++; $display("FAIL bok_read_data[%0d]: got %h exp %h", k, read_data, 32'hBEEF0000 + 32'(k)); end
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({replace, rready, arvalid, read_valid} !== 4'b0000) begin
      n_err++; $display("FAIL bok_done: got %b exp 0000", {replace, rready, arvalid, read_valid}); end
  endtask

  task automatic test_ar_backpressure();
    req_main(19'h55AA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({arvalid, rready} !== 2'b10) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %b exp 10", i, {arvalid, rready}); end
      n_cmp++; if (araddr !== 24'hAB54A0) begin
        n_err++; $display("FAIL bp_araddr[%0d]: got %h exp ab54a0", i, araddr); end
      @(posedge clk); #1;
    end
    arready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rvalid = 1'b1; rresp = 2'b00; rdata = 32'h11110000 + 32'(k); rlast = (k == 7);
      @(negedge clk);
      n_cmp++; if ({read_valid, read_addr} !== {1'b1, 3'(k)}) begin
        n_err++; $display("FAIL bp_beat[%0d]: got v=%b a=%0d exp v=1 a=%0d", k, read_valid, read_addr, k); end
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({replace, arvalid} !== 2'b00) begin
      n_err++; $display("FAIL bp_done: got %b exp 00", {replace, arvalid}); end
  endtask

  task automatic test_error_retry();
    req_main(19'h00ABC, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rvalid = 1'b1; rresp = (k == 3) ? 2'b10 : 2'b00; rdata = 32'h22220000 + 32'(k); rlast = (k == 7);
      @(negedge clk);
      n_cmp++; if ({read_valid, rready} !== {(k < 3), 1'b1}) begin
        n_err++; $display("FAIL err_first_pass[%0d]: got v=%b rdy=%b exp v=%b rdy=1", k, read_valid, rready, (k < 3)); end
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    @(negedge clk);
    n_cmp++; if ({arvalid, replace, rready} !== 3'b110) begin
      n_err++; $display("FAIL err_retry_ar: got %b exp 110", {arvalid, replace, rready}); end
    n_cmp++; if (araddr !== 24'h015780) begin
      n_err++; $display("FAIL err_retry_addr: got %h exp 015780", araddr); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rvalid = 1'b1; rresp = 2'b00; rdata = 32'h33330000 + 32'(k); rlast = (k == 7);
      @(negedge clk);
      n_cmp++; if ({read_valid, read_addr} !== {1'b1, 3'(k)}) begin
        n_err++; $display("FAIL err_retry_beat[%0d]: got v=%b a=%0d exp v=1 a=%0d", k, read_valid, read_addr, k); end
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({replace, arvalid} !== 2'b00) begin
      n_err++; $display("FAIL err_done: got %b exp 00", {replace, arvalid}); end
  endtask

  task automatic test_r_gaps();
    int gaps[8] = '{0, 2, 1, 0, 3, 0, 1, 2};
    req_main(19'h00042, 1'b1);
    @(negedge clk);
    n_cmp++; if (araddr !== 24'h000840) begin
      n_err++; $display("FAIL gap_araddr: got %h exp 000840", araddr); end
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        @(posedge clk); #1;
        rvalid = 1'b0; rresp = 2'b10; rdata = 32'hDEADDEAD; rlast = 1'b0;
        @(negedge clk);
        n_cmp++; if ({read_valid, rready} !== 2'b01) begin
          n_err++; $display("FAIL gap_idle[%0d.%0d]: got %b exp 01", k, g, {read_valid, rready}); end
      end
      @(posedge clk); #1;
      rvalid = 1'b1; rresp = 2'b00; rdata = 32'h44440000 + 32'(k); rlast = (k == 7);
      @(negedge clk);
      n_cmp++; if ({read_valid, read_addr} !== {1'b1, 3'(k)}) begin
        n_err++; $display("FAIL gap_beat[%0d]: got v=%b a=%0d exp v=1 a=%0d", k, read_valid, read_addr, k); end
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    @(negedge clk);
    n_cmp++; if ({replace, arvalid} !== 2'b00) begin
      n_err++; $display("FAIL gap_done: got %b exp 00", {replace, arvalid}); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    replace_valid = 1'b1; replace_addr = 19'h00111; arready = 1'b1;
    @(posedge clk); #1;
    replace_addr = 19'h00222;
    @(negedge clk);
    n_cmp++; if (araddr !== 24'h002220) begin
      n_err++; $display("FAIL b2b_first_addr: got %h exp 002220", araddr); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rvalid = 1'b1; rresp = 2'b00; rdata = 32'h55550000 + 32'(k); rlast = (k == 7);
      @(negedge clk);
      n_cmp++; if ({read_valid, arvalid} !== 2'b10) begin
        n_err++; $display("FAIL b2b_busy_ignore[%0d]: got %b exp 10", k, {read_valid, arvalid}); end
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({replace, arvalid} !== 2'b00) begin
      n_err++; $display("FAIL b2b_idle_gap: got %b exp 00", {replace, arvalid}); end
    @(posedge clk); #1;
    replace_valid = 1'b0; replace_addr = 19'h7FFFF;
    @(negedge clk);
    n_cmp++; if ({arvalid, replace} !== 2'b11) begin
      n_err++; $display("FAIL b2b_second_ar: got %b exp 11", {arvalid, replace}); end
    n_cmp++; if (araddr !== 24'h004440) begin
      n_err++; $display("FAIL b2b_second_addr: got %h exp 004440", araddr); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rvalid = 1'b1; rresp = 2'b00; rdata = 32'h66660000 + 32'(k); rlast = (k == 7);
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if (replace !== 1'b0) begin
      n_err++; $display("FAIL b2b_done: got %b exp 0", replace); end
  endtask

  // Early rlast on beat 5: the burst still runs 8 beats; the checker (if built) flags it.
  task automatic test_rlast();
    req_main(19'h00300, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rvalid = 1'b1; rresp = 2'b00; rdata = 32'h77770000 + 32'(k); rlast = (k == 5);
      @(negedge clk);
      n_cmp++; if ({read_valid, replace, rready, read_addr} !== {3'b111, 3'(k)}) begin
        n_err++; $display("FAIL rl_beat[%0d]: got v=%b rep=%b rdy=%b a=%0d exp 1 1 1 %0d",
                          k, read_valid, replace, rready, read_addr, k); end
`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
      n_cmp++; if (rlast_err !== (k > 5)) begin
        n_err++; $display("FAIL rl_err_flag[%0d]: got %b exp %b", k, rlast_err, (k > 5)); end
`endif
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    n_cmp++; if ({replace, arvalid} !== 2'b00) begin
      n_err++; $display("FAIL rl_done: got %b exp 00", {replace, arvalid}); end
`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (rlast_err !== 1'b1) begin
      n_err++; $display("FAIL rl_err_sticky: got %b exp 1", rlast_err); end
`endif
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    s_replace_valid = 1'b1; s_replace_addr = 22'h12345; s_arready = 1'b1;
    @(posedge clk); #1;
    s_replace_valid = 1'b0; s_replace_addr = 22'h0;
    @(negedge clk);
    n_cmp++; if ({s_arvalid, s_araddr} !== {1'b1, 24'h048D14}) begin
      n_err++; $display("FAIL sg_ar: got v=%b a=%h exp v=1 a=048d14", s_arvalid, s_araddr); end
    n_cmp++; if ({s_arlen, s_arburst, s_arsize} !== {8'd0, 2'b00, 3'd2}) begin
      n_err++; $display("FAIL sg_ar_fields: got len=%0d burst=%b size=%0d exp 0 00 2", s_arlen, s_arburst, s_arsize); end
    @(posedge clk); #1;
    s_rvalid = 1'b1; s_rresp = 2'b00; s_rdata = 32'hCAFEF00D; s_rlast = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s_read_valid, s_read_addr, s_read_data} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL sg_beat: got v=%b a=%b d=%h exp 1 0 cafef00d", s_read_valid, s_read_addr, s_read_data); end
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({s_replace, s_rready} !== 2'b00) begin
      n_err++; $display("FAIL sg_done: got %b exp 00", {s_replace, s_rready}); end
    @(posedge clk); #1;
    s_replace_valid = 1'b1; s_replace_addr = 22'h00001;
    @(posedge clk); #1;
    s_replace_valid = 1'b0;
    @(posedge clk); #1;
    s_rvalid = 1'b1; s_rresp = 2'b11;
    @(negedge clk);
    n_cmp++; if ({s_read_valid, s_rready} !== 2'b01) begin
      n_err++; $display("FAIL sg_err_beat: got %b exp 01", {s_read_valid, s_rready}); end
    @(posedge clk); #1;
    s_rvalid = 1'b0; s_rresp = 2'b00;
    @(negedge clk);
    n_cmp++; if ({s_arvalid, s_araddr} !== {1'b1, 24'h000004}) begin
      n_err++; $display("FAIL sg_retry_ar: got v=%b a=%h exp v=1 a=000004", s_arvalid, s_araddr); end
    @(posedge clk); #1;
    @(negedge clk);
    #1 s_rvalid = 1'b1;
    #1;
    n_cmp++; if ({s_rready, s_read_valid} !== 2'b11) begin
      n_err++; $display("FAIL sg_pre_reset: got %b exp 11", {s_rready, s_read_valid}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({s_replace, s_arvalid, s_rready, s_read_valid} !== 4'b0000) begin
      n_err++; $display("FAIL sg_async_reset: got %b exp 0000", {s_replace, s_arvalid, s_rready, s_read_valid}); end
    @(posedge clk); #1;
    s_rvalid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s_replace, s_arvalid, s_rready, replace} !== 4'b0000) begin
      n_err++; $display("FAIL sg_after_reset: got %b exp 0000", {s_replace, s_arvalid, s_rready, replace}); end
`ifdef IOB_CACHE_READ_RLAST_CHECK_EN
    n_cmp++; if (rlast_err !== 1'b0) begin
      n_err++; $display("FAIL sg_rlast_err_cleared: got %b exp 0", rlast_err); end
`endif
  endtask

  initial begin
    replace_valid = 1'b0; replace_addr = '0; arready = 1'b0; rid = '0;
    rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    s_replace_valid = 1'b0; s_replace_addr = '0; s_arready = 1'b0; s_rid = '0;
    s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0; s_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_burst_ok();
    test_ar_backpressure();
    test_error_retry();
    test_r_gaps();
    test_back_to_back();
    test_rlast();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
